// File: rtl/pixel_pkg.sv
// pixel_pkg: pixel/word geometry shared by split_pixels, concat_pixels and
// pixel_lane_select. Lane k of a word occupies bits [k*PIXEL_W +: PIXEL_W],
// so lane 0 (pixel1) sits in the least-significant byte.
package pixel_pkg;
    localparam int PIXEL_W         = 8;
    localparam int PIXELS_PER_WORD = 4;
    localparam int WORD_W          = PIXEL_W * PIXELS_PER_WORD;
    localparam int LANE_IDX_W      = $clog2(PIXELS_PER_WORD);

    typedef logic [PIXEL_W-1:0] pixel_t;
    typedef logic [WORD_W-1:0]  word_t;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } split_state_t;
endpackage

// File: rtl/pixel_lane_select.sv
// pixel_lane_select: combinational lane mux, packed word + lane index -> pixel.
// Ports:
//   i_word  [PIXEL_W*PIXELS_PER_WORD-1:0]  packed word
//   i_lane  [log2(PIXELS_PER_WORD)-1:0]    lane to extract
//   o_pixel [PIXEL_W-1:0]                  selected pixel
module pixel_lane_select
    import pixel_pkg::*;
#(
    parameter int PIXEL_W_P         = PIXEL_W,
    parameter int PIXELS_PER_WORD_P = PIXELS_PER_WORD,
    localparam int WORD_W_P         = PIXEL_W_P * PIXELS_PER_WORD_P,
    localparam int LANE_W_P         = $clog2(PIXELS_PER_WORD_P)
) (
    input  logic [WORD_W_P-1:0]  i_word,
    input  logic [LANE_W_P-1:0]  i_lane,
    output logic [PIXEL_W_P-1:0] o_pixel
);
    always_comb begin
        o_pixel = i_word[i_lane*PIXEL_W_P +: PIXEL_W_P];
    end
endmodule

// File: rtl/split_pixels.sv
// split_pixels: unpacks one packed word into a serial pixel stream, lane 0
// first, one pixel per cycle, valid/ready on both sides.
// Ports:
//   clk, rst                synchronous active-high reset
//   word_in/valid/ready     upstream word handshake
//   pixel_out/valid/ready   downstream pixel handshake
//   word_last, pixel_last   only with SPLIT_PIXELS_LAST_EN defined; pixel_last
//                           marks the final lane of a word flagged word_last
// PIXELS_PER_WORD must be a power of two >= 2 so the lane counter wraps
// naturally. word_ready depends combinationally on pixel_ready: it is the only
// input-to-output path, and it is what lets a new word load on the same edge
// the last lane leaves, so back-to-back words stream with no bubble.
module split_pixels
    import pixel_pkg::*;
#(
    parameter int PIXEL_W_P         = PIXEL_W,
    parameter int PIXELS_PER_WORD_P = PIXELS_PER_WORD,
    localparam int WORD_W_P         = PIXEL_W_P * PIXELS_PER_WORD_P,
    localparam int LANE_W_P         = $clog2(PIXELS_PER_WORD_P)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [WORD_W_P-1:0]  word_in,
    input  logic                 word_valid,
    output logic                 word_ready,
`ifdef SPLIT_PIXELS_LAST_EN
    input  logic                 word_last,
    output logic                 pixel_last,
`endif
    output logic [PIXEL_W_P-1:0] pixel_out,
    output logic                 pixel_valid,
    input  logic                 pixel_ready
);
    localparam logic [LANE_W_P-1:0] LAST_LANE = LANE_W_P'(PIXELS_PER_WORD_P - 1);

    split_state_t         r_state;
    logic [WORD_W_P-1:0]  r_word;
    logic [LANE_W_P-1:0]  r_lane;
`ifdef SPLIT_PIXELS_LAST_EN
    logic                 r_last;
`endif

    logic w_xfer;
    logic w_last_lane;
    logic w_accept;

    assign pixel_valid = (r_state == FULL);
    assign w_xfer      = pixel_valid && pixel_ready;
    assign w_last_lane = (r_lane == LAST_LANE);
    assign word_ready  = (r_state == EMPTY) || (w_xfer && w_last_lane);
    assign w_accept    = word_valid && word_ready;

    // Output is always taken from the held word, never from word_in, so it
    // stays stable under backpressure and reads 0 after reset.
    pixel_lane_select #(
        .PIXEL_W_P         (PIXEL_W_P),
        .PIXELS_PER_WORD_P (PIXELS_PER_WORD_P)
    ) u_sel (
        .i_word  (r_word),
        .i_lane  (r_lane),
        .o_pixel (pixel_out)
    );

`ifdef SPLIT_PIXELS_LAST_EN
    assign pixel_last = r_last && w_last_lane && pixel_valid;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= EMPTY;
            r_word  <= '0;
            r_lane  <= '0;
`ifdef SPLIT_PIXELS_LAST_EN
            r_last  <= 1'b0;
`endif
        end else if (w_accept) begin
            // Covers both the idle load and the reload on the last-lane edge.
            r_state <= FULL;
            r_word  <= word_in;
            r_lane  <= '0;
`ifdef SPLIT_PIXELS_LAST_EN
            r_last  <= word_last;
`endif
        end else if (w_xfer) begin
            r_lane <= r_lane + LANE_W_P'(1);
            if (w_last_lane) begin
                r_state <= EMPTY;
            end
        end
    end
endmodule

// File: tb/tb_split_pixels.sv
module tb_split_pixels;
    import pixel_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] word_in = '0;
    logic        word_valid = 1'b0;
    logic        word_ready;
    logic [7:0]  pixel_out;
    logic        pixel_valid;
    logic        pixel_ready = 1'b1;
    logic        word_last = 1'b0;
`ifdef SPLIT_PIXELS_LAST_EN
    logic        pixel_last;
`endif

    split_pixels dut (
        .clk         (clk),
        .rst         (rst),
        .word_in     (word_in),
        .word_valid  (word_valid),
        .word_ready  (word_ready),
`ifdef SPLIT_PIXELS_LAST_EN
        .word_last   (word_last),
        .pixel_last  (pixel_last),
`endif
        .pixel_out   (pixel_out),
        .pixel_valid (pixel_valid),
        .pixel_ready (pixel_ready)
    );

    always #5 clk = ~clk;

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [8:0]  exp_q[$];   // {last, pixel}
    bit          rand_en = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Monitor: every pixel handshake pops the next expected pixel.
    always @(negedge clk) begin
        if (!rst && pixel_valid && pixel_ready) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_pixel: got %0h expected none", pixel_out);
            end else begin
                logic [8:0] e;
                e = exp_q.pop_front();
                chk("pixel_out", {24'd0, pixel_out}, {24'd0, e[7:0]});
`ifdef SPLIT_PIXELS_LAST_EN
                chk("pixel_last", {31'd0, pixel_last}, {31'd0, e[8]});
`endif
            end
        end
    end

    // Present a word and hold it until accepted; returns the number of
    // negedges spent waiting (1 = accepted on the first edge). Returns at
    // accept edge + 1.
    task automatic send(input logic [31:0] w, input logic last, output int waits);
        bit ok;
        ok = 1'b0;
        waits = 0;
        word_in = w;
        word_last = last;
        word_valid = 1'b1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            waits++;
            if (word_ready) begin
                ok = 1'b1;
                break;
            end
            @(posedge clk);
            #1;
            if (rand_en) pixel_ready = 1'($urandom_range(0, 1));
        end
        if (!ok) begin
            n_cmp++;
            n_bad++;
            $display("FAIL accept_timeout: got no word_ready expected accept of %0h", w);
        end else begin
            for (int k = 0; k < 4; k++)
                exp_q.push_back({last && (k == 3), w[k*8 +: 8]});
        end
        @(posedge clk);
        #1;
        if (rand_en) pixel_ready = 1'($urandom_range(0, 1));
    endtask

    task automatic drain();
        pixel_ready = 1'b1;
        for (int i = 0; i < 50 && exp_q.size() != 0; i++) @(posedge clk);
        @(posedge clk);
        #1;
        chk("drain_empty", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        int w;
        // Reset held with a word offered: it must not be taken.
        rst = 1'b1;
        word_in = 32'h12345678;
        word_valid = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        word_valid = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_pixel_valid", {31'd0, pixel_valid}, 32'd0);
        chk("rst_pixel_out", {24'd0, pixel_out}, 32'd0);
        chk("rst_word_ready", {31'd0, word_ready}, 32'd1);
        @(posedge clk);
        #1;

        // Single word, ready held high.
        send(32'h44332211, 1'b1, w);
        word_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("single_pixel_valid", {31'd0, pixel_valid}, 32'd1);
            chk("single_word_ready", {31'd0, word_ready}, {31'd0, i == 3});
        end
        @(negedge clk);
        chk("single_idle_after", {31'd0, pixel_valid}, 32'd0);
        @(posedge clk);
        #1;

        // Back-to-back: second accept must coincide with the last lane.
        send(32'h44332211, 1'b0, w);
        send(32'h88776655, 1'b0, w);
        chk("b2b_accept_wait", 32'(w), 32'd4);
        word_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("b2b_pixel_valid", {31'd0, pixel_valid}, 32'd1);
        end
        @(negedge clk);
        chk("b2b_idle_after", {31'd0, pixel_valid}, 32'd0);
        drain();

        // Backpressure while showing 0x22.
        send(32'h44332211, 1'b0, w);
        word_valid = 1'b0;
        @(posedge clk);
        #1;
        pixel_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("bp_hold_pixel", {24'd0, pixel_out}, 32'h22);
            chk("bp_word_ready", {31'd0, word_ready}, 32'd0);
            chk("bp_valid", {31'd0, pixel_valid}, 32'd1);
            @(posedge clk);
            #1;
        end
        pixel_ready = 1'b1;
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("bp_resume", {24'd0, pixel_out}, 32'h33);
        drain();

        // Reset mid-word after 0x11 and 0x22.
        send(32'h44332211, 1'b0, w);
        word_valid = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        exp_q.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("midrst_valid", {31'd0, pixel_valid}, 32'd0);
        chk("midrst_pixel_out", {24'd0, pixel_out}, 32'd0);
        chk("midrst_word_ready", {31'd0, word_ready}, 32'd1);
        @(posedge clk);
        #1;
        send(32'hDDCCBBAA, 1'b0, w);
        word_valid = 1'b0;
        drain();

        // Random backpressure, 1000 words.
        rand_en = 1'b1;
        for (int i = 0; i < 1000; i++)
            send($urandom, 1'($urandom_range(0, 1)), w);
        word_valid = 1'b0;
        rand_en = 1'b0;
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule
